// File: rtl/interrupt_controller.sv
// Return-address stack sequencer and prioritised interrupt controller.
// Decides each cycle between decoder call/ret/reti and external interrupt
// requests, drives the stack strobes and PC-source select, and keeps its own
// copy of stack depth and ISR call nesting so illegal sequences are blocked
// (the offending instruction is squashed and the block locks into FAULT).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   RUN    | normal program flow, interrupts may be accepted
//   ISR    | inside an interrupt handler, no further interrupts accepted
//   FAULT  | sequencing error seen, everything squashed until reset
module interrupt_controller #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [9:0]  VEC_BASE   = 10'h3C0,
  parameter logic [9:0]  VEC_STRIDE = 10'd4,
  parameter int          DEPTH      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               call,
  input  logic               ret,
  input  logic               reti,
  output logic               push,
  output logic               pop,
  output logic               interrupt,
  output logic [1:0]         pc_sel,
  output logic [9:0]         vec_addr,
  output logic               squash,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr,
  output logic               fault
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [1:0] PC_NEXT  = 2'b00;
  localparam logic [1:0] PC_VEC   = 2'b01;
  localparam logic [1:0] PC_STACK = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_ISR   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t             state;
  logic [DW-1:0]      depth;
  logic [DW-1:0]      isr_depth;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rise;
  logic [IW-1:0]      win_idx;
  logic [1:0]         op_count;
  logic               multi_op;
  logic               stack_full;
  logic               stack_empty;

  logic               do_accept;
  logic               do_fault;
  logic               do_leave;
  logic               depth_inc;
  logic               depth_dec;
  logic               isr_inc;
  logic               isr_dec;

  assign eligible    = pending & mask;
  assign rise        = irq & ~irq_q;
  assign op_count    = {1'b0, call} + {1'b0, ret} + {1'b0, reti};
  assign multi_op    = (op_count > 2'd1);
  assign stack_full  = (depth == DW'(DEPTH));
  assign stack_empty = (depth == '0);

  // Lowest-numbered eligible line wins; scanning downward leaves the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = IW'(i);
    end
  end

  // Strobe decode; everything is held at zero while reset is asserted.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    interrupt = 1'b0;
    pc_sel    = PC_NEXT;
    vec_addr  = '0;
    squash    = 1'b0;
    irq_ack   = '0;
    do_accept = 1'b0;
    do_fault  = 1'b0;
    do_leave  = 1'b0;
    depth_inc = 1'b0;
    depth_dec = 1'b0;
    isr_inc   = 1'b0;
    isr_dec   = 1'b0;
    if (reset) begin
      unique case (state)
        ST_RUN: begin
          if ((|eligible) && !stack_full) begin
            // The interrupted instruction is squashed; its own PC is saved.
            push             = 1'b1;
            squash           = 1'b1;
            pc_sel           = PC_VEC;
            vec_addr         = VEC_BASE + 10'(win_idx) * VEC_STRIDE;
            irq_ack[win_idx] = 1'b1;
            do_accept        = 1'b1;
          end else if (multi_op) begin
            squash   = 1'b1;
            do_fault = 1'b1;
          end else if (call) begin
            if (!stack_full) begin
              push      = 1'b1;
              depth_inc = 1'b1;
            end else begin
              squash   = 1'b1;
              do_fault = 1'b1;
            end
          end else if (ret) begin
            if (!stack_empty) begin
              pop       = 1'b1;
              pc_sel    = PC_STACK;
              depth_dec = 1'b1;
            end else begin
              squash   = 1'b1;
              do_fault = 1'b1;
            end
          end else if (reti) begin
            squash   = 1'b1;
            do_fault = 1'b1;
          end
        end
        ST_ISR: begin
          if (multi_op) begin
            squash   = 1'b1;
            do_fault = 1'b1;
          end else if (call) begin
            if (!stack_full) begin
              push      = 1'b1;
              depth_inc = 1'b1;
              isr_inc   = 1'b1;
            end else begin
              squash   = 1'b1;
              do_fault = 1'b1;
            end
          end else if (ret) begin
            // isr_depth > 0 implies the stack holds at least the ISR frame too.
            if (isr_depth != '0) begin
              pop       = 1'b1;
              pc_sel    = PC_STACK;
              depth_dec = 1'b1;
              isr_dec   = 1'b1;
            end else begin
              squash   = 1'b1;
              do_fault = 1'b1;
            end
          end else if (reti) begin
            if (isr_depth == '0) begin
              pop       = 1'b1;
              interrupt = 1'b1;
              pc_sel    = PC_STACK;
              do_leave  = 1'b1;
            end else begin
              squash   = 1'b1;
              do_fault = 1'b1;
            end
          end
        end
        default: begin
          squash = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state, stack depth tracking and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      depth     <= '0;
      isr_depth <= '0;
      in_isr    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      if (do_fault) begin
        state  <= ST_FAULT;
        in_isr <= 1'b0;
        fault  <= 1'b1;
      end else if (do_accept) begin
        state     <= ST_ISR;
        in_isr    <= 1'b1;
        depth     <= depth + DW'(1);
        isr_depth <= '0;
      end else if (do_leave) begin
        state  <= ST_RUN;
        in_isr <= 1'b0;
        depth  <= depth - DW'(1);
      end else begin
        if (depth_inc) depth <= depth + DW'(1);
        if (depth_dec) depth <= depth - DW'(1);
        if (isr_inc)   isr_depth <= isr_depth + DW'(1);
        if (isr_dec)   isr_depth <= isr_depth - DW'(1);
      end
    end
  end

  // Edge capture, pending latch (a new edge beats a same-cycle ack) and mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~irq_ack) | rise;
      if (mask_we) mask <= mask_in;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a frame-stack model.
module tb_interrupt_controller;

  localparam int N = 4;
  localparam int D = 16;
  localparam byte FR_CALL = 8'd1;
  localparam byte FR_ISR  = 8'd2;
  localparam int A_NONE = 0, A_ACCEPT = 1, A_PUSH = 2, A_POP = 3, A_FAULT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irq = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_in = '0;
  logic         call = 1'b0, ret = 1'b0, reti = 1'b0;
  logic         push, pop, interrupt, squash, in_isr, fault;
  logic [1:0]   pc_sel;
  logic [9:0]   vec_addr;
  logic [N-1:0] irq_ack;

  int checks = 0;
  int failures = 0;

  interrupt_controller #(.NUM_IRQ(N), .VEC_BASE(10'h3C0), .VEC_STRIDE(10'd4), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .call(call), .ret(ret), .reti(reti), .push(push), .pop(pop),
    .interrupt(interrupt), .pc_sel(pc_sel), .vec_addr(vec_addr), .squash(squash),
    .irq_ack(irq_ack), .in_isr(in_isr), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stack as a list of frames, each either a call frame or an ISR frame.
  byte      stk[$];
  bit [N-1:0] m_pend, m_mask, m_prev;
  bit       m_faulted;
  int       p_act, p_k;
  bit [N-1:0] p_irq, p_min;
  bit       p_mwe;

  function automatic bit has_isr_frame();
    foreach (stk[i]) if (stk[i] == FR_ISR) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    stk.delete();
    m_pend = '0; m_mask = '0; m_prev = '0;
    m_faulted = 1'b0;
    p_act = A_NONE; p_k = 0;
  endfunction

  // Compare process: expected outputs from the model, checked mid-cycle.
  always @(negedge clk) begin
    bit e_push, e_pop, e_int, e_sq, e_isr, e_flt;
    bit [1:0] e_pc;
    bit [9:0] e_vec;
    bit [N-1:0] e_ack, elig;
    int nops, k;
    e_push = 0; e_pop = 0; e_int = 0; e_sq = 0; e_isr = 0; e_flt = 0;
    e_pc = 0; e_vec = 0; e_ack = 0;
    p_act = A_NONE;
    p_irq = irq; p_mwe = mask_we; p_min = mask_in;
    if (!reset) begin
      model_clear();
    end else begin
      e_isr = has_isr_frame() && !m_faulted;
      e_flt = m_faulted;
      elig = m_pend & m_mask;
      nops = int'(call) + int'(ret) + int'(reti);
      if (m_faulted) begin
        e_sq = 1;
      end else if (!e_isr && elig != 0 && stk.size() < D) begin
        k = 0;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) k = i;
        e_push = 1; e_sq = 1; e_pc = 2'b01;
        e_vec = 10'h3C0 + 10'(k * 4);
        e_ack = N'(1) << k;
        p_act = A_ACCEPT; p_k = k;
      end else if (nops > 1) begin
        e_sq = 1; p_act = A_FAULT;
      end else if (call) begin
        if (stk.size() < D) begin e_push = 1; p_act = A_PUSH; end
        else begin e_sq = 1; p_act = A_FAULT; end
      end else if (ret) begin
        if (stk.size() > 0 && stk[$] == FR_CALL) begin e_pop = 1; e_pc = 2'b10; p_act = A_POP; end
        else begin e_sq = 1; p_act = A_FAULT; end
      end else if (reti) begin
        if (e_isr && stk.size() > 0 && stk[$] == FR_ISR) begin
          e_pop = 1; e_int = 1; e_pc = 2'b10; p_act = A_POP;
        end else begin e_sq = 1; p_act = A_FAULT; end
      end
    end
    chk("push", push, e_push);
    chk("pop", pop, e_pop);
    chk("interrupt", interrupt, e_int);
    chk("pc_sel", pc_sel, e_pc);
    chk("vec_addr", vec_addr, e_vec);
    chk("squash", squash, e_sq);
    chk("irq_ack", irq_ack, e_ack);
    chk("in_isr", in_isr, e_isr);
    chk("fault", fault, e_flt);
  end

  // Model commit at the active edge.
  always @(posedge clk) begin
    bit [N-1:0] ack;
    if (!reset) begin
      model_clear();
    end else begin
      ack = '0;
      case (p_act)
        A_ACCEPT: begin stk.push_back(FR_ISR); ack[p_k] = 1'b1; end
        A_PUSH:   stk.push_back(FR_CALL);
        A_POP:    void'(stk.pop_back());
        A_FAULT:  m_faulted = 1'b1;
        default:  ;
      endcase
      m_pend = (m_pend & ~ack) | (p_irq & ~m_prev);
      m_prev = p_irq;
      if (p_mwe) m_mask = p_min;
    end
  end

  task automatic cyc(input bit c, input bit r, input bit ri, input logic [N-1:0] iv,
                     input bit mwe, input logic [N-1:0] mi);
    @(posedge clk);
    #1;
    call = c; ret = r; reti = ri; irq = iv; mask_we = mwe; mask_in = mi;
    #6;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    call = 0; ret = 0; reti = 0; irq = '0; mask_we = 0; mask_in = '0;
    #1;
    chk("rst_in_isr", in_isr, 0);
    chk("rst_fault", fault, 0);
    chk("rst_squash", squash, 0);
    chk("rst_push", push, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_isr", in_isr, 0);
    chk("reset_fault", fault, 0);
    reset = 1'b1;

    // Basic interrupt, nested calls inside the ISR, reti.
    cyc(0, 0, 0, 4'b0000, 1, 4'b0011);
    cyc(0, 0, 0, 4'b0010, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0010, 0, 4'b0000);
    chk("acc_push", push, 1); chk("acc_squash", squash, 1); chk("acc_pcsel", pc_sel, 2'b01);
    chk("acc_vec", vec_addr, 10'h3C4); chk("acc_ack", irq_ack, 4'b0010); chk("acc_in_isr", in_isr, 0);
    cyc(0, 0, 0, 4'b0010, 0, 4'b0000);
    chk("isr_entered", in_isr, 1); chk("isr_idle_push", push, 0);
    cyc(1, 0, 0, 4'b0010, 0, 4'b0000); chk("isr_call1", push, 1);
    cyc(1, 0, 0, 4'b0010, 0, 4'b0000); chk("isr_call2", push, 1);
    cyc(0, 1, 0, 4'b0010, 0, 4'b0000); chk("isr_ret1_pop", pop, 1); chk("isr_ret1_int", interrupt, 0);
    cyc(0, 1, 0, 4'b0010, 0, 4'b0000); chk("isr_ret2_pop", pop, 1); chk("isr_ret2_pc", pc_sel, 2'b10);
    cyc(0, 0, 1, 4'b0010, 0, 4'b0000);
    chk("reti_pop", pop, 1); chk("reti_int", interrupt, 1); chk("reti_pc", pc_sel, 2'b10);
    cyc(0, 0, 0, 4'b0010, 0, 4'b0000); chk("after_reti", in_isr, 0);

    // Priority and masking.
    cyc(0, 0, 0, 4'b0000, 1, 4'b1100);
    cyc(0, 0, 0, 4'b1101, 0, 4'b0000);
    cyc(0, 0, 0, 4'b1101, 0, 4'b0000);
    chk("prio_vec2", vec_addr, 10'h3C8); chk("prio_ack2", irq_ack, 4'b0100);
    cyc(0, 0, 0, 4'b1101, 0, 4'b0000);
    cyc(0, 0, 1, 4'b1101, 0, 4'b0000); chk("reti_no_accept", irq_ack, 4'b0000);
    cyc(0, 0, 0, 4'b1101, 0, 4'b0000);
    chk("prio_vec3", vec_addr, 10'h3CC); chk("prio_ack3", irq_ack, 4'b1000);
    cyc(0, 0, 1, 4'b1101, 0, 4'b0000);
    cyc(0, 0, 0, 4'b1101, 0, 4'b0000); chk("masked_line0", irq_ack, 4'b0000);
    cyc(0, 0, 0, 4'b1101, 1, 4'b1111); chk("old_mask_used", push, 0);
    cyc(0, 0, 0, 4'b1101, 0, 4'b0000);
    chk("line0_vec", vec_addr, 10'h3C0); chk("line0_ack", irq_ack, 4'b0001);
    cyc(0, 0, 1, 4'b1101, 0, 4'b0000);

    // Overflow guard.
    for (int i = 0; i < D; i++) begin
      cyc(1, 0, 0, 4'b0000, 0, 4'b0000);
      chk("fill_push", push, 1);
    end
    cyc(0, 0, 0, 4'b0010, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0010, 0, 4'b0000); chk("full_no_accept", irq_ack, 4'b0000);
    cyc(1, 0, 0, 4'b0010, 0, 4'b0000);
    chk("ovf_push", push, 0); chk("ovf_squash", squash, 1);
    cyc(0, 0, 0, 4'b0010, 0, 4'b0000);
    chk("ovf_fault", fault, 1); chk("ovf_sticky_sq", squash, 1); chk("ovf_pc", pc_sel, 2'b00);
    async_reset();

    // Illegal sequencing.
    cyc(0, 1, 0, 4'b0000, 0, 4'b0000); chk("ret0_pop", pop, 0); chk("ret0_sq", squash, 1);
    cyc(0, 0, 0, 4'b0000, 0, 4'b0000); chk("ret0_fault", fault, 1);
    async_reset();
    cyc(0, 0, 1, 4'b0000, 0, 4'b0000); chk("retirun_pop", pop, 0); chk("retirun_sq", squash, 1);
    cyc(0, 0, 0, 4'b0000, 0, 4'b0000); chk("retirun_fault", fault, 1);
    async_reset();

    // Reset mid-ISR.
    cyc(0, 0, 0, 4'b0000, 1, 4'b0001);
    cyc(0, 0, 0, 4'b0001, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0001, 0, 4'b0000); chk("pre_rst_ack", irq_ack, 4'b0001);
    cyc(0, 0, 0, 4'b0001, 0, 4'b0000); chk("pre_rst_isr", in_isr, 1);
    async_reset();
    cyc(0, 0, 0, 4'b0000, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0001, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0001, 0, 4'b0000); chk("post_rst_masked", push, 0);
    cyc(0, 0, 0, 4'b0001, 1, 4'b0001); chk("post_rst_oldmask", push, 0);
    cyc(0, 0, 0, 4'b0001, 0, 4'b0000); chk("post_rst_ack", irq_ack, 4'b0001);
    cyc(0, 0, 1, 4'b0001, 0, 4'b0000);

    // Randomized traffic.
    begin
      int fcnt = 0;
      for (int n = 0; n < 4000; n++) begin
        int r;
        bit c, rt, ri, need_rst;
        logic [N-1:0] iv;
        @(posedge clk);
        #1;
        if (m_faulted) fcnt++; else fcnt = 0;
        need_rst = (fcnt > 3) || ($urandom_range(0, 599) == 0);
        if (need_rst) begin
          reset = 1'b0;
          call = 0; ret = 0; reti = 0; irq = '0; mask_we = 0; mask_in = '0;
          fcnt = 0;
          continue;
        end
        reset = 1'b1;
        iv = irq;
        for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) iv[b] = ~iv[b];
        c = 0; rt = 0; ri = 0;
        r = $urandom_range(0, 99);
        if (r < 45) begin
        end else if (r < 68) begin
          c = 1;
        end else if (r < 96) begin
          if (stk.size() > 0) begin
            if (stk[$] == FR_ISR) ri = 1; else rt = 1;
          end
        end else begin
          {c, rt, ri} = 3'($urandom_range(1, 7));
        end
        call = c; ret = rt; reti = ri; irq = iv;
        mask_we = ($urandom_range(0, 15) == 0);
        mask_in = N'($urandom);
      end
    end
    @(posedge clk);
    #1;
    call = 0; ret = 0; reti = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences the 16-entry, 10-bit return-address stack (`pila`) for the single-cycle CPU.
- Arbitrates each cycle between decoder call/ret/reti and prioritised external interrupt requests.
- Drives the stack's push/pop/interrupt strobes and the PC-source select.
- Tracks stack depth and ISR nesting so stack overflow and underflow are prevented, never merely flagged.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines (1..8).
- VEC_BASE, 10'h3C0, address of the vector for irq[0].
- VEC_STRIDE, 10'd4, address distance between consecutive vectors.
- DEPTH, 16, stack capacity; must match the stack memory.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq  input  NUM_IRQ  external requests; rising-edge sensitive.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  NUM_IRQ  new mask value; 1 = line enabled.
- call  input  1  decoder: current instruction is a call.
- ret  input  1  decoder: current instruction is a return.
- reti  input  1  decoder: current instruction is a return-from-interrupt.
- push  output  1  to stack push.
- pop  output  1  to stack pop.
- interrupt  output  1  to stack; 1 = return to the saved PC itself, not saved PC + 1.
- pc_sel  output  2  PC source: 00 CPU next-PC, 01 vec_addr, 10 stack out.
- vec_addr  output  10  vector of the accepted line.
- squash  output  1  suppress register/memory writes of the current instruction.
- irq_ack  output  NUM_IRQ  one-hot, high in the acceptance cycle.
- in_isr  output  1  state == ISR.
- fault  output  1  sticky sequencing error.

Behaviour:

Reset (reset low, asynchronous):
- State = RUN; depth = 0; isr_depth = 0.
- pending = 0; mask = 0 (all lines masked); irq_q = 0.
- All outputs 0.

Registered state:
- Edge detect: irq_q <= irq each cycle. Rising edge on line i sets pending[i] at that clock edge.
- Latency: irq rising before edge n sets pending at edge n; acceptance can occur in cycle n+1.
- mask_we: mask <= mask_in at the clock edge. Acceptance in the same cycle uses the old mask.
- State machine: RUN, ISR, FAULT.
- depth: 0..DEPTH, mirrors stack occupancy.
- isr_depth: 0..DEPTH, counts calls made inside the current ISR.

All strobes (push, pop, interrupt, pc_sel, squash, irq_ack) are combinational from current state and inputs, and are valid within the same cycle.

Priority in RUN, highest first:
1. Interrupt accept: eligible = pending & mask is non-zero and depth < DEPTH.
   - Winning line k = lowest set index of eligible.
   - Outputs: push=1, interrupt=0, squash=1, pc_sel=01, vec_addr = VEC_BASE + k*VEC_STRIDE, irq_ack[k]=1.
   - At the edge: pending[k] cleared, depth+1, state -> ISR, isr_depth = 0.
   - Any call/ret in the same cycle is squashed. That instruction re-executes after reti because its own PC was saved.
2. Decoder operations:
   - call with depth < DEPTH: push=1, depth+1. pc_sel=00; the CPU supplies the target.
   - ret with depth > 0: pop=1, pc_sel=10, interrupt=0, depth-1.
3. Otherwise: all strobes 0, pc_sel=00.

ISR state:
- No interrupt is accepted. New edges still latch into pending.
- call: as in RUN, plus isr_depth+1.
- ret with isr_depth > 0: as in RUN, plus isr_depth-1.
- reti with isr_depth == 0: pop=1, interrupt=1, pc_sel=10, depth-1, state -> RUN.
- Pending interrupts are not accepted in the reti cycle; earliest acceptance is the following cycle.

Faults: no stack strobe is issued, squash=1, and state -> FAULT at the edge. Fault conditions:
- call with depth == DEPTH.
- ret with depth == 0.
- ret in ISR with isr_depth == 0.
- reti in RUN.
- reti in ISR with isr_depth != 0.
- More than one of call/ret/reti asserted together.

FAULT state:
- fault=1, squash=1, push=pop=0, pc_sel=00, every cycle.
- Only reset exits.

Pending bit conflicts:
- Same bit acked and re-edged in one cycle: the set wins and the bit stays pending.

Reset mid-ISR:
- Everything clears. Stack contents are abandoned; depth=0 re-synchronises with the stack's own reset.

Test Plan:
- Basic interrupt: mask=4'b0011, irq[1] rises before edge 5, PC=0x020 -> cycle 6: push=1, squash=1, pc_sel=01, vec_addr=0x3C4, irq_ack=0010, in_isr=1 from cycle 7. Later reti -> pop=1, interrupt=1, pc_sel=10, PC resumes at 0x020.
- Priority and masking: irq[3], irq[2], irq[0] rise together, mask=4'b1100 -> line 2 accepted first (vec 0x3C8). Line 3 is taken in the cycle after reti. Line 0 stays pending until the mask enables it.
- Calls inside ISR: call, call, ret, ret, reti -> pop on the two rets with interrupt=0, then pop with interrupt=1 on reti; depth returns to its pre-interrupt value.
- Overflow guard: 16 calls, then a 17th call -> no push, fault=1, squash=1 sticky. An eligible interrupt at depth 16 is not accepted.
- Illegal sequencing: ret at depth 0 -> fault; also reti in RUN -> fault. In both, pop stays 0.
- Asynchronous reset mid-ISR: pull reset low between edges -> in_isr, fault, pending, depth and mask clear immediately. The next irq edge is ignored until mask is written.
